// File: rtl/door_ctl.sv
// Sliding door sequencer: watches plate/button and player positions, steps the
// door open/hold/close once per frame tick and drives passable/level/state.
module door_ctl #(
    parameter int unsigned PLATE_X_MIN = 100,
    parameter int unsigned PLATE_X_MAX = 160,
    parameter int unsigned DOOR_X_MIN  = 310,
    parameter int unsigned DOOR_X_MAX  = 450,
    parameter int unsigned DOOR_HEIGHT = 128,
    parameter int unsigned STEP        = 4,
    parameter int unsigned HOLD_FRAMES = 120
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        v_tick,
    input  logic [11:0] xpos_player1,
    input  logic [11:0] xpos_player2,
    input  logic        button_in,
    output logic [7:0]  door_lvl,
    output logic        door_passable,
    output logic [2:0]  door_state
);

    localparam logic [2:0] CLOSED  = 3'd0;
    localparam logic [2:0] OPENING = 3'd1;
    localparam logic [2:0] OPEN    = 3'd2;
    localparam logic [2:0] HOLD    = 3'd3;
    localparam logic [2:0] CLOSING = 3'd4;

    localparam int unsigned CW = $clog2(HOLD_FRAMES + 1);

    localparam logic [11:0] PX_MIN = 12'(PLATE_X_MIN);
    localparam logic [11:0] PX_MAX = 12'(PLATE_X_MAX);
    localparam logic [11:0] DX_MIN = 12'(DOOR_X_MIN);
    localparam logic [11:0] DX_MAX = 12'(DOOR_X_MAX);
    localparam logic [8:0]  HEIGHT = 9'(DOOR_HEIGHT);
    localparam logic [8:0]  STEP9  = 9'(STEP);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_FRAMES);

    logic          v_tick_old;
    logic          tick;
    logic          plate;
    logic          occupied;
    logic [2:0]    state, state_n;
    logic [7:0]    lvl_n;
    logic          pass_n;
    logic [CW-1:0] hold_cnt, hold_cnt_n;
    logic [8:0]    lvl_up;

    assign tick = v_tick & ~v_tick_old;

    assign plate = button_in
                 | ((xpos_player1 >= PX_MIN) && (xpos_player1 <= PX_MAX))
                 | ((xpos_player2 >= PX_MIN) && (xpos_player2 <= PX_MAX));

    assign occupied = ((xpos_player1 >= DX_MIN) && (xpos_player1 <= DX_MAX))
                    | ((xpos_player2 >= DX_MIN) && (xpos_player2 <= DX_MAX));

    // Opening sum is kept 9 bits wide so a full door plus STEP cannot wrap.
    assign lvl_up = {1'b0, door_lvl} + STEP9;

    always_comb begin
        state_n    = state;
        lvl_n      = door_lvl;
        hold_cnt_n = hold_cnt;
        if (tick) begin
            case (state)
                CLOSED: begin
                    lvl_n = '0;
                    if (plate)
                        state_n = OPENING;
                end
                OPENING: begin
                    if (lvl_up >= HEIGHT) begin
                        lvl_n   = HEIGHT[7:0];
                        state_n = OPEN;
                    end else begin
                        lvl_n = lvl_up[7:0];
                    end
                end
                OPEN: begin
                    if (!plate) begin
                        hold_cnt_n = HOLD_LOAD;
                        state_n    = HOLD;
                    end
                end
                HOLD: begin
                    if (plate)
                        state_n = OPEN;
                    else if (hold_cnt != '0)
                        hold_cnt_n = hold_cnt - CW'(1);
                    else if (!occupied)
                        state_n = CLOSING;
                end
                CLOSING: begin
                    if (plate || occupied) begin
                        state_n = OPENING;
                    end else if ({1'b0, door_lvl} <= STEP9) begin
                        lvl_n   = '0;
                        state_n = CLOSED;
                    end else begin
                        lvl_n = door_lvl - STEP9[7:0];
                    end
                end
                default: begin
                    state_n = CLOSED;
                    lvl_n   = '0;
                end
            endcase
        end
        pass_n = (state_n == OPEN) || (state_n == HOLD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_tick_old    <= 1'b0;
            state         <= CLOSED;
            door_lvl      <= '0;
            door_passable <= 1'b0;
            hold_cnt      <= '0;
        end else begin
            v_tick_old    <= v_tick;
            state         <= state_n;
            door_lvl      <= lvl_n;
            door_passable <= pass_n;
            hold_cnt      <= hold_cnt_n;
        end
    end

    assign door_state = state;

endmodule

// File: tb/tb_door_ctl.sv
// Self-checking bench for door_ctl: a behavioural model pushes expected
// {state, passable, level} per frame tick; each test pops and compares.
module tb_door_ctl;

    localparam int P_MIN = 100, P_MAX = 160, D_MIN = 310, D_MAX = 450;
    localparam int HEIGHT = 128, STP = 4, HOLDF = 120;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        v_tick = 1'b0;
    logic [11:0] xpos_player1 = '0;
    logic [11:0] xpos_player2 = '0;
    logic        button_in = 1'b0;
    logic [7:0]  door_lvl;
    logic        door_passable;
    logic [2:0]  door_state;

    door_ctl #(
        .PLATE_X_MIN(P_MIN), .PLATE_X_MAX(P_MAX),
        .DOOR_X_MIN(D_MIN), .DOOR_X_MAX(D_MAX),
        .DOOR_HEIGHT(HEIGHT), .STEP(STP), .HOLD_FRAMES(HOLDF)
    ) dut (
        .clk(clk), .rst(rst), .v_tick(v_tick),
        .xpos_player1(xpos_player1), .xpos_player2(xpos_player2),
        .button_in(button_in), .door_lvl(door_lvl),
        .door_passable(door_passable), .door_state(door_state)
    );

    always #5 clk = ~clk;

    int chk_cnt = 0;
    int pass_cnt = 0;
    logic [11:0] sb[$];
    logic [11:0] e, obs, obs_late;

    int m_state = 0, m_lvl = 0, m_cnt = 0;
    bit m_pass = 0;

    function automatic bit in_rng(input int x, input int lo, input int hi);
        return (x >= lo) && (x <= hi);
    endfunction

    task automatic model_reset();
        m_state = 0; m_lvl = 0; m_cnt = 0; m_pass = 0;
        sb.push_back({3'd0, 1'b0, 8'd0});
    endtask

    task automatic model_step();
        bit plate, occ;
        int x1, x2;
        x1 = int'(xpos_player1);
        x2 = int'(xpos_player2);
        plate = button_in || in_rng(x1, P_MIN, P_MAX) || in_rng(x2, P_MIN, P_MAX);
        occ = in_rng(x1, D_MIN, D_MAX) || in_rng(x2, D_MIN, D_MAX);
        case (m_state)
            0: begin m_lvl = 0; if (plate) m_state = 1; end
            1: begin
                m_lvl = m_lvl + STP;
                if (m_lvl >= HEIGHT) begin m_lvl = HEIGHT; m_state = 2; end
            end
            2: if (!plate) begin m_cnt = HOLDF; m_state = 3; end
            3: begin
                if (plate) m_state = 2;
                else if (m_cnt > 0) m_cnt = m_cnt - 1;
                else if (!occ) m_state = 4;
            end
            4: begin
                if (plate || occ) m_state = 1;
                else begin
                    m_lvl = m_lvl - STP;
                    if (m_lvl <= 0) begin m_lvl = 0; m_state = 0; end
                end
            end
            default: begin m_state = 0; m_lvl = 0; end
        endcase
        m_pass = (m_state == 2) || (m_state == 3);
        sb.push_back({3'(m_state), m_pass, 8'(m_lvl)});
    endtask

    // One frame: v_tick rises, stays high for `high` clocks, then falls.
    task automatic frame(input int high);
        model_step();
        @(negedge clk); v_tick = 1'b1;
        @(posedge clk); #1;
        obs = {door_state, door_passable, door_lvl};
        repeat (high - 1) @(posedge clk);
        #1;
        obs_late = {door_state, door_passable, door_lvl};
        @(negedge clk); v_tick = 1'b0;
        @(posedge clk);
    endtask

    task automatic async_reset();
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        obs = {door_state, door_passable, door_lvl};
        model_reset();
        e = sb.pop_front();
        chk_cnt++;
        if (obs !== e)
            $display("FAIL async_reset: got st=%0d ps=%0b lvl=%0d, want st=%0d ps=%0b lvl=%0d",
                     obs[11:9], obs[8], obs[7:0], e[11:9], e[8], e[7:0]);
        else pass_cnt++;
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        obs = {door_state, door_passable, door_lvl};
        model_reset();
        e = sb.pop_front();
        chk_cnt++;
        if (obs !== e)
            $display("FAIL reset_state: got st=%0d ps=%0b lvl=%0d, want st=%0d ps=%0b lvl=%0d",
                     obs[11:9], obs[8], obs[7:0], e[11:9], e[8], e[7:0]);
        else pass_cnt++;
        @(negedge clk); rst = 1'b1;
        xpos_player1 = 12'd0; xpos_player2 = 12'd0; button_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            frame(1);
            e = sb.pop_front();
            chk_cnt++;
            if (obs !== e)
                $display("FAIL idle tick%0d: got st=%0d ps=%0b lvl=%0d, want st=%0d ps=%0b lvl=%0d",
                         i, obs[11:9], obs[8], obs[7:0], e[11:9], e[8], e[7:0]);
            else pass_cnt++;
        end
    endtask

    task automatic test_open();
        xpos_player1 = 12'd120;
        for (int i = 1; i <= 33; i++) begin
            frame(1);
            e = sb.pop_front();
            chk_cnt++;
            if (obs !== e)
                $display("FAIL open tick%0d: got st=%0d ps=%0b lvl=%0d, want st=%0d ps=%0b lvl=%0d",
                         i, obs[11:9], obs[8], obs[7:0], e[11:9], e[8], e[7:0]);
            else pass_cnt++;
        end
    endtask

    task automatic test_hold_close();
        int n = 0;
        xpos_player1 = 12'd200;
        xpos_player2 = 12'd0;
        do begin
            frame(1);
            n++;
            e = sb.pop_front();
            chk_cnt++;
            if (obs !== e)
                $display("FAIL hold_close tick%0d: got st=%0d ps=%0b lvl=%0d, want st=%0d ps=%0b lvl=%0d",
                         n, obs[11:9], obs[8], obs[7:0], e[11:9], e[8], e[7:0]);
            else pass_cnt++;
        end while (m_state != 0 && n < 300);
        chk_cnt++;
        if (n != 1 + HOLDF + 1 + 32)
            $display("FAIL hold_close_len: got %0d ticks, want %0d", n, 1 + HOLDF + 1 + 32);
        else pass_cnt++;
    endtask

    task automatic test_occupied_hold();
        int n = 0;
        xpos_player1 = 12'd120;
        do begin
            frame(1);
            n++;
            e = sb.pop_front();
            chk_cnt++;
            if (obs !== e)
                $display("FAIL reopen tick%0d: got st=%0d ps=%0b lvl=%0d, want st=%0d ps=%0b lvl=%0d",
                         n, obs[11:9], obs[8], obs[7:0], e[11:9], e[8], e[7:0]);
            else pass_cnt++;
        end while (m_state != 2 && n < 100);
        xpos_player1 = 12'd200;
        xpos_player2 = 12'd380;
        for (int i = 0; i < 1 + HOLDF + 5; i++) begin
            frame(1);
            e = sb.pop_front();
            chk_cnt++;
            if (obs !== e)
                $display("FAIL occ_hold tick%0d: got st=%0d ps=%0b lvl=%0d, want st=%0d ps=%0b lvl=%0d",
                         i, obs[11:9], obs[8], obs[7:0], e[11:9], e[8], e[7:0]);
            else pass_cnt++;
        end
        xpos_player2 = 12'd500;
        frame(1);
        e = sb.pop_front();
        chk_cnt++;
        if (obs !== e)
            $display("FAIL occ_leave: got st=%0d ps=%0b lvl=%0d, want st=%0d ps=%0b lvl=%0d",
                     obs[11:9], obs[8], obs[7:0], e[11:9], e[8], e[7:0]);
        else pass_cnt++;
    endtask

    task automatic test_reversal();
        int n = 0;
        for (int i = 0; i < 16; i++) begin
            frame(1);
            e = sb.pop_front();
            chk_cnt++;
            if (obs !== e)
                $display("FAIL close_to64 tick%0d: got st=%0d ps=%0b lvl=%0d, want st=%0d ps=%0b lvl=%0d",
                         i, obs[11:9], obs[8], obs[7:0], e[11:9], e[8], e[7:0]);
            else pass_cnt++;
        end
        button_in = 1'b1;
        frame(1);
        button_in = 1'b0;
        do begin
            e = sb.pop_front();
            chk_cnt++;
            if (obs !== e)
                $display("FAIL reversal tick%0d: got st=%0d ps=%0b lvl=%0d, want st=%0d ps=%0b lvl=%0d",
                         n, obs[11:9], obs[8], obs[7:0], e[11:9], e[8], e[7:0]);
            else pass_cnt++;
            n++;
            frame(1);
        end while (m_state != 2 && n < 50);
        e = sb.pop_front();
        chk_cnt++;
        if (obs !== e)
            $display("FAIL reversal_open: got st=%0d ps=%0b lvl=%0d, want st=%0d ps=%0b lvl=%0d",
                     obs[11:9], obs[8], obs[7:0], e[11:9], e[8], e[7:0]);
        else pass_cnt++;
    endtask

    task automatic test_long_tick_reset();
        async_reset();
        xpos_player1 = 12'd120;
        xpos_player2 = 12'd0;
        for (int i = 1; i <= 11; i++) begin
            frame(i == 10 ? 50 : 1);
            e = sb.pop_front();
            chk_cnt++;
            if (obs !== e)
                $display("FAIL long_tick tick%0d: got st=%0d ps=%0b lvl=%0d, want st=%0d ps=%0b lvl=%0d",
                         i, obs[11:9], obs[8], obs[7:0], e[11:9], e[8], e[7:0]);
            else pass_cnt++;
            if (i == 10) begin
                chk_cnt++;
                if (obs_late !== e)
                    $display("FAIL long_tick_held: got st=%0d ps=%0b lvl=%0d, want st=%0d ps=%0b lvl=%0d",
                             obs_late[11:9], obs_late[8], obs_late[7:0], e[11:9], e[8], e[7:0]);
                else pass_cnt++;
            end
        end
        async_reset();
    endtask

    task automatic test_plate_edges();
        logic [11:0] p1[3] = '{12'd99, 12'd161, 12'd0};
        logic [11:0] p2[3] = '{12'd0, 12'd0, 12'd160};
        for (int i = 0; i < 3; i++) begin
            xpos_player1 = p1[i];
            xpos_player2 = p2[i];
            frame(1);
            e = sb.pop_front();
            chk_cnt++;
            if (obs !== e)
                $display("FAIL plate_edge%0d: got st=%0d ps=%0b lvl=%0d, want st=%0d ps=%0b lvl=%0d",
                         i, obs[11:9], obs[8], obs[7:0], e[11:9], e[8], e[7:0]);
            else pass_cnt++;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_open();
        test_hold_close();
        test_occupied_hold();
        test_reversal();
        test_long_tick_reset();
        test_plate_edges();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
